rr_grant_sequencer16: RTL

- Round-robin arbiter and sequencer that shares one 16-way one-hot-selected resource among 16 requesters.
- Picks one requester and drives a registered one-hot grant vector plus its 4-bit index. The grant vector is the 4-to-16 decoded form of the index, gated by an enable.
- Holds the grant until the owner drops its request, the block is disabled, or a hold timeout expires. Then rotates priority past the last owner.
- Sits between the requesting engines and the shared select/decode path.

---
 rtl/rr_grant_sequencer16.sv | 101 ++++++++++
 1 files changed

// File: rtl/rr_grant_sequencer16.sv
// Round-robin arbiter/sequencer: grants one of 16 requesters, holds the grant until
// the owner drops, the block is disabled, or MAX_HOLD expires, then rotates past the owner.
module rr_grant_sequencer16 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        E,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic        timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  state_t              state, state_nxt;
  logic [3:0]          ptr, ptr_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [15:0]         gnt_nxt;
  logic [3:0]          idx_nxt;
  logic                valid_nxt, timeout_nxt;

  logic [15:0]         rot;
  logic [3:0]          offset, winner;
  logic                rel_drop, rel_off, rel_max, rel_any;

  // Rotate req so bit 0 is the current priority position; the lowest set bit wins.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    rot    = 16'({req, req} >> ptr);
    offset = '0;
    for (int i = 15; i >= 0; i--) begin
      if (rot[i]) offset = 4'(i);
    end
    winner = ptr + offset;
  end

  always_comb begin
    rel_drop = !req[gnt_idx];
    rel_off  = !E;
    rel_max  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    rel_any  = rel_drop || rel_off || rel_max;
  end

  // State register together with the registered outputs and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values together.
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      gnt       <= gnt_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (E && (|req)) state_nxt = GRANT;
      GRANT:   if (rel_any)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ptr_nxt     = ptr;
    hold_nxt    = '0;
    idx_nxt     = gnt_idx;
    timeout_nxt = 1'b0;
    if (state == IDLE && state_nxt == GRANT) begin
      idx_nxt = winner;
    end else if (state == GRANT) begin
      if (rel_any) begin
        ptr_nxt     = gnt_idx + 4'd1;
        timeout_nxt = rel_max && !rel_drop && !rel_off;
      end else begin
        // Saturates only when MAX_HOLD is 0; otherwise release happens first.
        hold_nxt = (hold_cnt == '1) ? hold_cnt : hold_cnt + HOLD_W'(1);
      end
    end
    valid_nxt = (state_nxt == GRANT);
    gnt_nxt   = valid_nxt ? (16'h0001 << idx_nxt) : 16'h0000;
  end

endmodule
